// File: rtl/req_pulse_pkg.sv
// Shared channel-state type and default stall limit for req_pulse_arb.
// StErr exists only when REQ_PULSE_TIMEOUT_EN is defined.
package req_pulse_pkg;

  localparam int unsigned TimeoutCycDefault = 255;

  typedef enum logic [2:0] {
    StIdle,
    StPend,
    StGrant,
    StAcked
`ifdef REQ_PULSE_TIMEOUT_EN
    , StErr
`endif
  } ch_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, which
// moves to one past the granted index whenever the grant is consumed.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic            gnt_en_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  // Two passes: indices at/after the pointer first, then wrap around to the rest.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid_o && req_i[i] && (i >= 32'(ptr_q))) begin
        valid_o  = 1'b1;
        idx_o    = IdxW'(i);
        gnt_o[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid_o && req_i[i]) begin
        valid_o  = 1'b1;
        idx_o    = IdxW'(i);
        gnt_o[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_en_i && valid_o) begin
      ptr_d = (32'(idx_o) == N - 1) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/req_pulse_arb.sv
// Serialises rising edges on NCH 4-phase request channels into a single
// valid/ready event stream; optional stall timeout under REQ_PULSE_TIMEOUT_EN.
module req_pulse_arb
  import req_pulse_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned IDX_W       = $clog2(NCH),
  parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   req_en,
  output logic [NCH-1:0]   ack,
  output logic             pulse_valid,
  output logic [IDX_W-1:0] pulse_ch,
  input  logic             pulse_ready
`ifdef REQ_PULSE_TIMEOUT_EN
  ,
  output logic [NCH-1:0]   timeout_err
`endif
);

  ch_state_e        state_q [NCH];
  ch_state_e        state_d [NCH];
  logic [NCH-1:0]   prev_q, prev_d;
  logic [NCH-1:0]   ack_q, ack_d;
  logic [NCH-1:0]   rise, arb_req, arb_gnt;
  logic             post_rst_q;
  logic             pulse_valid_q, pulse_valid_d;
  logic [IDX_W-1:0] pulse_ch_q, pulse_ch_d, arb_idx;
  logic             arb_valid, accept, slot_free, grant_en;

  assign prev_d    = req & req_en;
  assign rise      = prev_d & ~prev_q;
  assign accept    = pulse_valid_q & pulse_ready;
  assign slot_free = ~pulse_valid_q | accept;
  assign grant_en  = slot_free & arb_valid;

  // A channel that dropped req/req_en this cycle is cancelling, so it must not win.
  always_comb begin
    arb_req = '0;
    for (int i = 0; i < NCH; i++) begin
      arb_req[i] = (state_q[i] == StPend) & req[i] & req_en[i];
    end
  end

  rr_arbiter #(
    .N    (NCH),
    .IdxW (IDX_W)
  ) u_rr_arbiter (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (arb_req),
    .gnt_en_i (grant_en),
    .gnt_o    (arb_gnt),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

`ifdef REQ_PULSE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [NCH-1:0]  timeout_err_q, timeout_err_d;
  logic            stall, drop;

  assign stall = pulse_valid_q & ~pulse_ready;
  assign drop  = stall & (32'(tmo_cnt_q) == TIMEOUT_CYC - 1);

  always_comb begin
    tmo_cnt_d     = '0;
    timeout_err_d = '0;
    if (stall && !drop) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if (drop) begin
      timeout_err_d[pulse_ch_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= '0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = |TIMEOUT_CYC;
`endif

  // At most one channel is ever in StGrant, and it is the one in the output slot.
  always_comb begin
    ack_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        StIdle: begin
          if (rise[i] && !post_rst_q) state_d[i] = StPend;
        end
        StPend: begin
          if (!(req[i] && req_en[i])) begin
            state_d[i] = StIdle;
          end else if (grant_en && arb_gnt[i]) begin
            state_d[i] = StGrant;
          end
        end
        StGrant: begin
          if (accept) begin
            state_d[i] = req[i] ? StAcked : StIdle;
`ifdef REQ_PULSE_TIMEOUT_EN
          end else if (drop) begin
            state_d[i] = StErr;
`endif
          end
        end
        StAcked: begin
          if (!req[i]) state_d[i] = StIdle;
        end
`ifdef REQ_PULSE_TIMEOUT_EN
        StErr: begin
          if (!req[i]) state_d[i] = StIdle;
        end
`endif
        default: state_d[i] = StIdle;
      endcase
      ack_d[i] = (state_d[i] == StAcked);
    end
  end

  always_comb begin
    pulse_valid_d = pulse_valid_q;
    pulse_ch_d    = pulse_ch_q;
    if (accept) pulse_valid_d = 1'b0;
`ifdef REQ_PULSE_TIMEOUT_EN
    if (drop) pulse_valid_d = 1'b0;
`endif
    if (grant_en) begin
      pulse_valid_d = 1'b1;
      pulse_ch_d    = arb_idx;
    end
  end

  // post_rst_q masks capture for the first cycle after reset so a held req cannot fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= StIdle;
      end
      prev_q        <= '0;
      ack_q         <= '0;
      pulse_valid_q <= 1'b0;
      pulse_ch_q    <= '0;
      post_rst_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      ack_q         <= ack_d;
      pulse_valid_q <= pulse_valid_d;
      pulse_ch_q    <= pulse_ch_d;
      post_rst_q    <= 1'b0;
    end
  end

  assign ack         = ack_q;
  assign pulse_valid = pulse_valid_q;
  assign pulse_ch    = pulse_ch_q;

endmodule

// File: doc/req_pulse_arb.md
REQ_PULSE_ARB -- requirements
Module: req_pulse_arb

Interface
REQ-001 Parameter NCH, default 4, number of independent 4-phase request channels (2..32).
REQ-002 Parameter IDX_W, default $clog2(NCH), width of the channel index.
REQ-003 Parameter TIMEOUT_CYC, default 255, stall limit in cycles; used only when REQ_PULSE_TIMEOUT_EN is defined.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  reset: synchronous and active-high.
REQ-006 req  in  NCH  per-channel level request from software/CPU side.
REQ-007 req_en  in  NCH  per-channel capture enable.
REQ-008 ack  out  NCH  per-channel registered acknowledge level.
REQ-009 pulse_valid  out  1  registered: one serialized request event is presented.
REQ-010 pulse_ch  out  IDX_W  channel index of the presented event.
REQ-011 pulse_ready  in  1  downstream accepts the event when high together with pulse_valid.
REQ-012 timeout_err  out  NCH  one-cycle error pulse per channel; present only with REQ_PULSE_TIMEOUT_EN.

Function
REQ-013 Each channel SHALL run a state machine IDLE, PEND, GRANT, ACKED (plus ERR with the macro).
REQ-014 Each channel SHALL keep a registered previous sample of req & req_en; rising edge = req & req_en & ~prev.
REQ-015 IDLE->PEND on a rising edge; a level held high from reset or from a prior completed handshake SHALL NOT retrigger.
REQ-016 PEND->IDLE with no event emitted if req or req_en is low at an edge (cancel).
REQ-017 The arbiter SHALL grant one PEND channel per cycle when the output slot is empty or is being accepted that cycle; the granted channel goes PEND->GRANT, pulse_valid=1 and pulse_ch=index from the next cycle.
REQ-018 Arbitration SHALL be round-robin, starting after the last granted index; after reset, priority starts at channel 0.
REQ-019 pulse_valid and pulse_ch SHALL hold stable until acceptance; once valid, the event SHALL NOT be retracted.
REQ-020 On acceptance: GRANT->ACKED and ack=1 from the next cycle if req is high; GRANT->IDLE with ack=0 if req is low.
REQ-021 ACKED->IDLE and ack=0 from the cycle after req is sampled low; req_en low alone SHALL NOT drop ack.
REQ-022 Back-to-back acceptance SHALL be supported: with continuous pulse_ready and K pending channels, K events issue on K consecutive cycles.
REQ-023 Minimum latency SHALL be 2 cycles: rising edge sampled at edge E0; pulse_valid high after E1; ack high after the accepting edge.
REQ-024 Simultaneous rising edges on several channels SHALL all reach PEND; none SHALL be lost.
REQ-025 A new rising edge on a channel in GRANT or ACKED SHALL be ignored.

Reset
REQ-026 When rst is high at a clock edge: all channels IDLE, prev samples 0, ack=0, pulse_valid=0, pulse_ch=0, round-robin pointer=0, timeout counter=0, timeout_err=0.
REQ-027 Reset mid-handshake SHALL discard in-flight events; a req still high after reset SHALL NOT generate an event until it falls and rises again. This holds because prev is reset to 0 but the IDLE capture is qualified for one cycle after reset release.

Configuration
REQ-028 Macro REQ_PULSE_TIMEOUT_EN defined: one counter SHALL count cycles with pulse_valid & ~pulse_ready.
- When the count reaches TIMEOUT_CYC, the event SHALL be dropped (pulse_valid=0 next cycle).
- The channel SHALL go GRANT->ERR with timeout_err[ch] pulsed for one cycle.
- ERR holds ack=0 and returns to IDLE when req is sampled low.
- The counter SHALL clear on acceptance or drop.
REQ-029 Macro undefined: no counter, no ERR state, no timeout_err port; the slot waits indefinitely.

Structure
REQ-030 Package req_pulse_pkg SHALL hold the channel-state enum typedef and the default TIMEOUT_CYC constant.
REQ-031 Sub-module rr_arbiter (parameter N; request vector, grant one-hot, index, pointer update on grant) SHALL be instantiated once.

Verification
REQ-032 Single event: NCH=4, req[2] rises, pulse_ready=1 -> pulse_valid 2 cycles later, pulse_ch=2, ack[2]=1 next cycle; req[2] low -> ack[2]=0 one cycle later.
REQ-033 Contention: req[0..3] rise in the same cycle, pulse_ready=1 -> events issue on 4 consecutive cycles in order 0,1,2,3; the next burst after the last grant of 3 starts at 0.
REQ-034 Backpressure: pulse_ready=0 for 10 cycles with req[1] pending -> pulse_valid and pulse_ch=1 stable for all 10 cycles, one event only.
REQ-035 Cancel and gating: req[3] high for 1 cycle, then low while in PEND -> no event, ack[3]=0. req_en[3]=0 during a rising edge -> no event.
REQ-036 Reset: rst mid-GRANT with req high -> all outputs 0; no event until req falls and rises again.
REQ-037 Timeout (macro defined, TIMEOUT_CYC=8): pulse_ready held 0 -> pulse_valid drops after 8 stall cycles, timeout_err[ch] pulses for 1 cycle, ack stays 0.
